clockn_trigger: RTL and testbench

Derives a divided 50%-duty clock and a programmable-duty clock from a fast input clock. Re-times an external trigger level onto whole periods of the divided clock. Drives both onto SMA output ports under control of two mode switches. Sits between the board-level fast oscillator and the SMA connectors and also exports its select/enable state for external buffers and indicators.

---
 rtl/clockn_trigger.sv | 106 ++++++++++
 tb/tb_clockn_trigger.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clockn_trigger.sv
// Divides fastclk into a 50% clock and a programmable-duty clock, re-times a trigger
// onto divided-clock periods and drives the SMA ports. CLOCKN_TRIGGER_SYNC_EN selects 2-flop input sync.
`timescale 1ns/1ps
module clockn_trigger #(
   parameter int unsigned DIV       = 8,
   parameter int unsigned DUTY_HIGH = 2
) (
   input  logic       fastclk,
   input  logic       reset,
   input  logic       trigger,
   input  logic [1:0] Switches,
   output logic       clk_out,
   output logic       clk_out_DC,
   output logic       Clock_sel,
   output logic       Trig_sel,
   output logic       Trig_en,
   output logic       SMA_CLK_PORT,
   output logic       SMA_TRIG_PORT
);

   localparam int unsigned CW = $clog2(DIV);
   localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
   localparam logic [CW-1:0] CNT_HALF = CW'(DIV / 2);
   localparam logic [CW-1:0] CNT_DUTY = CW'(DUTY_HIGH);

   // in_s = {trigger, Switches[1], Switches[0]} after input retiming
   logic [2:0]    in_s;
   logic [CW-1:0] cnt;

   logic          boundary_c;
   logic [CW-1:0] cnt_nxt_c;
   logic          clk_nxt_c;
   logic          dc_nxt_c;
   logic          clock_sel_nxt_c;
   logic          trig_sel_nxt_c;
   logic          trig_en_nxt_c;
   logic          sma_clk_nxt_c;
   logic          sma_trig_nxt_c;

`ifdef CLOCKN_TRIGGER_SYNC_EN
   logic [2:0] in_meta;

   always_ff @(posedge fastclk or negedge reset) begin
      if (!reset) begin
         in_meta <= '0;
         in_s    <= '0;
      end else begin
         in_meta <= {trigger, Switches};
         in_s    <= in_meta;
      end
   end
`else
   always_ff @(posedge fastclk or negedge reset) begin
      if (!reset) begin
         in_s <= '0;
      end else begin
         in_s <= {trigger, Switches};
      end
   end
`endif

   // Next-state of the divider and the boundary-sampled controls
   always_comb begin
      boundary_c      = (cnt == CNT_LAST);
      cnt_nxt_c       = boundary_c ? '0 : cnt + CW'(1);
      clock_sel_nxt_c = Clock_sel;
      trig_sel_nxt_c  = Trig_sel;
      trig_en_nxt_c   = Trig_en;
      sma_trig_nxt_c  = SMA_TRIG_PORT;

      if (boundary_c) begin
         clock_sel_nxt_c = in_s[0];
         trig_sel_nxt_c  = in_s[1];
         trig_en_nxt_c   = in_s[2];
         // single-pulse mode fires only on the period where Trig_en rises
         sma_trig_nxt_c  = in_s[1] ? (in_s[2] & ~Trig_en) : in_s[2];
      end

      clk_nxt_c     = (cnt_nxt_c < CNT_HALF);
      dc_nxt_c      = (cnt_nxt_c < CNT_DUTY);
      sma_clk_nxt_c = clock_sel_nxt_c ? dc_nxt_c : clk_nxt_c;
   end

   always_ff @(posedge fastclk or negedge reset) begin
      if (!reset) begin
         cnt           <= CNT_LAST;
         clk_out       <= 1'b0;
         clk_out_DC    <= 1'b0;
         Clock_sel     <= 1'b0;
         Trig_sel      <= 1'b0;
         Trig_en       <= 1'b0;
         SMA_CLK_PORT  <= 1'b0;
         SMA_TRIG_PORT <= 1'b0;
      end else begin
         cnt           <= cnt_nxt_c;
         clk_out       <= clk_nxt_c;
         clk_out_DC    <= dc_nxt_c;
         Clock_sel     <= clock_sel_nxt_c;
         Trig_sel      <= trig_sel_nxt_c;
         Trig_en       <= trig_en_nxt_c;
         SMA_CLK_PORT  <= sma_clk_nxt_c;
         SMA_TRIG_PORT <= sma_trig_nxt_c;
      end
   end

endmodule

// File: tb/tb_clockn_trigger.sv
// Randomized self-checking bench for clockn_trigger against a cycle-count reference model.
`timescale 1ns/1ps
module tb_clockn_trigger;

   localparam int DIV       = 8;
   localparam int DUTY_HIGH = 2;
`ifdef CLOCKN_TRIGGER_SYNC_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic       fastclk  = 1'b0;
   logic       reset    = 1'b1;
   logic       trigger  = 1'b0;
   logic [1:0] Switches = 2'b00;
   logic       clk_out, clk_out_DC, Clock_sel, Trig_sel, Trig_en, SMA_CLK_PORT, SMA_TRIG_PORT;

   int errors = 0;
   int checks = 0;

   clockn_trigger #(.DIV(DIV), .DUTY_HIGH(DUTY_HIGH)) dut (
      .fastclk      (fastclk),
      .reset        (reset),
      .trigger      (trigger),
      .Switches     (Switches),
      .clk_out      (clk_out),
      .clk_out_DC   (clk_out_DC),
      .Clock_sel    (Clock_sel),
      .Trig_sel     (Trig_sel),
      .Trig_en      (Trig_en),
      .SMA_CLK_PORT (SMA_CLK_PORT),
      .SMA_TRIG_PORT(SMA_TRIG_PORT)
   );

   initial forever #2 fastclk = ~fastclk;

   // Reference model: k counts posedges since reset release; boundaries are k % DIV == 0,
   // and each boundary sees the inputs as they were LAT posedges earlier.
   int        k = -1;
   bit        samp_trig[$];
   bit [1:0]  samp_sw[$];
   bit        e_clk, e_dc, e_csel, e_tsel, e_ten, e_strig, e_sclk;
   int        m_pos, m_idx;
   bit        m_t;
   bit [1:0]  m_s;

   always @(posedge fastclk or negedge reset) begin
      if (!reset) begin
         k = -1;
         samp_trig.delete();
         samp_sw.delete();
         {e_clk, e_dc, e_csel, e_tsel, e_ten, e_strig, e_sclk} = '0;
      end else begin
         k++;
         samp_trig.push_back(trigger);
         samp_sw.push_back(Switches);
         m_pos = k % DIV;
         e_clk = (m_pos < DIV / 2);
         e_dc  = (m_pos < DUTY_HIGH);
         if (m_pos == 0) begin
            m_idx   = k - LAT;
            m_t     = (m_idx >= 0) ? samp_trig[m_idx] : 1'b0;
            m_s     = (m_idx >= 0) ? samp_sw[m_idx] : 2'b00;
            e_strig = m_s[1] ? (m_t && !e_ten) : m_t;
            e_csel  = m_s[0];
            e_tsel  = m_s[1];
            e_ten   = m_t;
         end
         e_sclk = e_csel ? e_dc : e_clk;
      end
   end

   logic [6:0] obs, exp;

   task automatic step();
      @(posedge fastclk);
      #1;
   endtask

   task automatic test_reset();
      int hi_clk, hi_dc;
      hi_clk = 0;
      hi_dc  = 0;
      #1 reset = 1'b0;
      #2;
      obs = {clk_out, clk_out_DC, Clock_sel, Trig_sel, Trig_en, SMA_CLK_PORT, SMA_TRIG_PORT};
      checks++;
      if (obs !== 7'b0) begin
         errors++;
         $display("FAIL reset_outputs t=%0t got=%b exp=%b", $time, obs, 7'b0);
      end
      #1 reset = 1'b1;
      for (int i = 0; i < 3 * DIV; i++) begin
         step();
         obs = {clk_out, clk_out_DC, Clock_sel, Trig_sel, Trig_en, SMA_CLK_PORT, SMA_TRIG_PORT};
         exp = {e_clk, e_dc, e_csel, e_tsel, e_ten, e_sclk, e_strig};
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL reset_restart cyc=%0d got=%b exp=%b", i, obs, exp);
         end
         if (i < 2 * DIV) begin
            hi_clk += int'(clk_out);
            hi_dc  += int'(clk_out_DC);
         end
      end
      checks++;
      if (hi_clk != DIV || hi_dc != 2 * DUTY_HIGH) begin
         errors++;
         $display("FAIL duty_count got clk=%0d dc=%0d exp clk=%0d dc=%0d", hi_clk, hi_dc, DIV, 2 * DUTY_HIGH);
      end
   endtask

   task automatic test_clock_select();
      int run, min_run;
      bit prev, first;
      repeat ($urandom_range(1, DIV - 1)) step();
      Switches = 2'b01;
      run = 0; min_run = 1000; first = 1'b1; prev = SMA_CLK_PORT;
      for (int i = 0; i < 4 * DIV; i++) begin
         step();
         obs = {clk_out, clk_out_DC, Clock_sel, Trig_sel, Trig_en, SMA_CLK_PORT, SMA_TRIG_PORT};
         exp = {e_clk, e_dc, e_csel, e_tsel, e_ten, e_sclk, e_strig};
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL clock_select cyc=%0d got=%b exp=%b", i, obs, exp);
         end
         if (SMA_CLK_PORT != prev) begin
            if (!first && run < min_run) min_run = run;
            first = 1'b0;
            run = 0;
            prev = SMA_CLK_PORT;
         end
         run++;
      end
      checks++;
      if (min_run < DUTY_HIGH) begin
         errors++;
         $display("FAIL sma_clk_runt got=%0d cycles exp>=%0d", min_run, DUTY_HIGH);
      end
      checks++;
      if (Clock_sel !== 1'b1) begin
         errors++;
         $display("FAIL clock_sel_final got=%b exp=1", Clock_sel);
      end
   endtask

   task automatic test_modes();
      logic [1:0] pat [2];
      pat[0] = 2'b10;
      pat[1] = 2'b11;
      for (int p = 0; p < 2; p++) begin
         Switches = pat[p];
         for (int i = 0; i < 2 * DIV + LAT; i++) begin
            step();
            obs = {clk_out, clk_out_DC, Clock_sel, Trig_sel, Trig_en, SMA_CLK_PORT, SMA_TRIG_PORT};
            exp = {e_clk, e_dc, e_csel, e_tsel, e_ten, e_sclk, e_strig};
            checks++;
            if (obs !== exp) begin
               errors++;
               $display("FAIL modes sw=%b cyc=%0d got=%b exp=%b", pat[p], i, obs, exp);
            end
         end
         checks++;
         if ({Trig_sel, Clock_sel} !== pat[p]) begin
            errors++;
            $display("FAIL mode_sel got=%b exp=%b", {Trig_sel, Clock_sel}, pat[p]);
         end
      end
   endtask

   task automatic test_level_trigger();
      int run, off;
      bit seen;
      Switches = 2'b00;
      repeat (2 * DIV + LAT) step();
      off = $urandom_range(0, DIV - 1);
      run = 0; seen = 1'b0;
      for (int i = 0; i < 5 * DIV; i++) begin
         if (i == off) trigger = 1'b1;
         if (i == off + 12) trigger = 1'b0;
         step();
         obs = {clk_out, clk_out_DC, Clock_sel, Trig_sel, Trig_en, SMA_CLK_PORT, SMA_TRIG_PORT};
         exp = {e_clk, e_dc, e_csel, e_tsel, e_ten, e_sclk, e_strig};
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL level_trigger cyc=%0d got=%b exp=%b", i, obs, exp);
         end
         if (Trig_en) run++;
         else if (run > 0) begin
            checks++;
            if (run % DIV != 0) begin
               errors++;
               $display("FAIL trig_en_width got=%0d cycles exp=multiple of %0d", run, DIV);
            end
            seen = 1'b1;
            run = 0;
         end
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL trig_en_timeout got=no fall exp=fall within %0d cycles", 5 * DIV);
      end
   endtask

   task automatic test_single_pulse();
      int hi, rises;
      bit prev;
      Switches = 2'b10;
      repeat (2 * DIV + LAT) step();
      hi = 0; rises = 0; prev = SMA_TRIG_PORT;
      for (int i = 0; i < 6 * DIV; i++) begin
         if (i == 2) trigger = 1'b1;
         if (i == 26) trigger = 1'b0;
         step();
         obs = {clk_out, clk_out_DC, Clock_sel, Trig_sel, Trig_en, SMA_CLK_PORT, SMA_TRIG_PORT};
         exp = {e_clk, e_dc, e_csel, e_tsel, e_ten, e_sclk, e_strig};
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL single_pulse cyc=%0d got=%b exp=%b", i, obs, exp);
         end
         hi += int'(SMA_TRIG_PORT);
         if (SMA_TRIG_PORT && !prev) rises++;
         prev = SMA_TRIG_PORT;
      end
      checks++;
      if (hi != DIV || rises != 1) begin
         errors++;
         $display("FAIL pulse_shape got high=%0d rises=%0d exp high=%0d rises=1", hi, rises, DIV);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 9) == 0) Switches = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 5) == 0) trigger = ~trigger;
         step();
         obs = {clk_out, clk_out_DC, Clock_sel, Trig_sel, Trig_en, SMA_CLK_PORT, SMA_TRIG_PORT};
         exp = {e_clk, e_dc, e_csel, e_tsel, e_ten, e_sclk, e_strig};
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL random cyc=%0d got=%b exp=%b", i, obs, exp);
         end
      end
   endtask

   task automatic test_async_reset();
      int n;
      n = 0;
      while (clk_out !== 1'b1 && n < DIV) begin
         step();
         n++;
      end
      checks++;
      if (clk_out !== 1'b1) begin
         errors++;
         $display("FAIL wait_clk_high got=%b exp=1 within %0d cycles", clk_out, DIV);
      end
      reset = 1'b0;
      #1;
      obs = {clk_out, clk_out_DC, Clock_sel, Trig_sel, Trig_en, SMA_CLK_PORT, SMA_TRIG_PORT};
      checks++;
      if (obs !== 7'b0) begin
         errors++;
         $display("FAIL async_reset got=%b exp=%b", obs, 7'b0);
      end
      Switches = 2'($urandom_range(0, 3));
      trigger  = 1'($urandom_range(0, 1));
      #1 reset = 1'b1;
      for (int i = 0; i < 4 * DIV; i++) begin
         step();
         obs = {clk_out, clk_out_DC, Clock_sel, Trig_sel, Trig_en, SMA_CLK_PORT, SMA_TRIG_PORT};
         exp = {e_clk, e_dc, e_csel, e_tsel, e_ten, e_sclk, e_strig};
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL async_restart cyc=%0d got=%b exp=%b", i, obs, exp);
         end
      end
   endtask

   initial begin
      test_reset();
      test_clock_select();
      test_modes();
      test_level_trigger();
      test_single_pulse();
      test_random();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
